// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial link transmitter and receiver.
package serial_link_pkg;

    // Transmitter control states, shared with the receiver side.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    // Shift register operation selected by the transmit FSM.
    typedef enum logic [1:0] {
        SR_HOLD = 2'd0,
        SR_LOAD = 2'd1,
        SR_SHL  = 2'd2
    } sr_mode_t;

    // Width of a counter that indexes the bits of an n-bit flit.
    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// N-bit shift register: parallel load, left shift with zero fill, or hold.
// Shifting a loaded flit N times leaves it all zeros, so the MSB is 0
// whenever no frame is in flight.
module ser_shift_reg
    import serial_link_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  sr_mode_t     mode,
    input  logic [N-1:0] load_data,
    output logic         msb
);

    logic [N-1:0] sr_r;

    // Register update: load a new flit, shift toward the MSB, or keep contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r <= '0;
        end else begin
            case (mode)
                SR_LOAD: sr_r <= load_data;
                SR_SHL:  sr_r <= {sr_r[N-2:0], 1'b0};
                SR_HOLD: sr_r <= sr_r;
                default: sr_r <= sr_r;
            endcase
        end
    end

    assign msb = sr_r[N-1];

endmodule

// File: rtl/serial_link_tx.sv
// Parallel-to-serial link transmitter: accepts one flit per valid/ready
// handshake and shifts it out MSB first with a frame strobe, optionally
// followed by a fixed number of idle gap cycles.
module serial_link_tx
    import serial_link_pkg::*;
#(
    parameter int N         = 8,
    parameter int FRAME_GAP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_out,
    output logic         ser_frame,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_w(N);
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((FRAME_GAP > 0) ? (FRAME_GAP - 1) : 0);

    tx_state_t     state_r;
    logic [CW-1:0] bit_cnt_r;
    logic [GW-1:0] gap_cnt_r;
    logic          ser_frame_r;
    logic          busy_r;
    logic          done_r;

    logic          last_bit_s;
    logic          in_ready_s;
    logic          hs_s;
    sr_mode_t      sr_mode_s;
    logic          sr_msb_s;

    // Handshake qualification and shift register control, decoded from state.
    // Reset forces in_ready low so a flit offered during reset is never taken.
    always_comb begin
        last_bit_s = 1'b0;
        in_ready_s = 1'b0;
        hs_s       = 1'b0;
        sr_mode_s  = SR_HOLD;

        last_bit_s = (state_r == SHIFT) && (bit_cnt_r == LAST_BIT);
        in_ready_s = !reset && ((state_r == IDLE) || ((FRAME_GAP == 0) && last_bit_s));
        hs_s       = in_valid && in_ready_s;

        if (hs_s) begin
            sr_mode_s = SR_LOAD;
        end else if (state_r == SHIFT) begin
            sr_mode_s = SR_SHL;
        end else begin
            sr_mode_s = SR_HOLD;
        end
    end

    ser_shift_reg #(
        .N (N)
    ) u_sr (
        .clk       (clk),
        .reset     (reset),
        .mode      (sr_mode_s),
        .load_data (in_data),
        .msb       (sr_msb_s)
    );

    // Transmit FSM with bit/gap counters and registered frame, busy, done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            ser_frame_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= 1'b0;
                    gap_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    if (hs_s) begin
                        state_r     <= SHIFT;
                        ser_frame_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        ser_frame_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                SHIFT: begin
                    done_r <= last_bit_s;
                    if (!last_bit_s) begin
                        state_r     <= SHIFT;
                        bit_cnt_r   <= bit_cnt_r + CW'(1);
                        ser_frame_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else if (FRAME_GAP > 0) begin
                        state_r     <= GAP;
                        bit_cnt_r   <= '0;
                        gap_cnt_r   <= GAP_LOAD;
                        ser_frame_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else if (hs_s) begin
                        // Back-to-back reload: next flit's MSB follows with no dead cycle.
                        state_r     <= SHIFT;
                        bit_cnt_r   <= '0;
                        ser_frame_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        bit_cnt_r   <= '0;
                        ser_frame_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                GAP: begin
                    done_r      <= 1'b0;
                    bit_cnt_r   <= '0;
                    ser_frame_r <= 1'b0;
                    if (gap_cnt_r == '0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r   <= GAP;
                        gap_cnt_r <= gap_cnt_r - GW'(1);
                        busy_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    bit_cnt_r   <= '0;
                    gap_cnt_r   <= '0;
                    ser_frame_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign ser_out   = sr_msb_s;
    assign ser_frame = ser_frame_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_serial_link_tx.sv
// Scoreboard bench for serial_link_tx. Three instances cover the gap
// configurations (N=8 gap 1, N=8 gap 0, N=4 gap 3). Stimulus pushes the
// hand-computed per-cycle output vector {ser_out, ser_frame, busy, done,
// in_ready} into the instance's queue; a negedge monitor pops and compares.
module tb_serial_link_tx;

    typedef struct {
        logic [4:0] v;
        string      tag;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       valid_a, valid_b, valid_c;

    logic rdy_a, so_a, fr_a, bz_a, dn_a;
    logic rdy_b, so_b, fr_b, bz_b, dn_b;
    logic rdy_c, so_c, fr_c, bz_c, dn_c;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int pass_cnt;
    int total_cnt;

    serial_link_tx #(.N(8), .FRAME_GAP(1)) dut_a (
        .clk(clk), .reset(reset), .in_data(data), .in_valid(valid_a),
        .in_ready(rdy_a), .ser_out(so_a), .ser_frame(fr_a), .busy(bz_a), .done(dn_a)
    );

    serial_link_tx #(.N(8), .FRAME_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .in_data(data), .in_valid(valid_b),
        .in_ready(rdy_b), .ser_out(so_b), .ser_frame(fr_b), .busy(bz_b), .done(dn_b)
    );

    serial_link_tx #(.N(4), .FRAME_GAP(3)) dut_c (
        .clk(clk), .reset(reset), .in_data(data[3:0]), .in_valid(valid_c),
        .in_ready(rdy_c), .ser_out(so_c), .ser_frame(fr_c), .busy(bz_c), .done(dn_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string who, input string tag,
                           input logic [4:0] act, input logic [4:0] expv);
        total_cnt++;
        if (act === expv) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s %s: got {so,fr,busy,done,rdy}=%b expected %b (t=%0t)",
                     who, tag, act, expv, $time);
        end
    endtask

    // Monitor: mid-cycle, compare each instance against its next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            compare("A", e.tag, {so_a, fr_a, bz_a, dn_a, rdy_a}, e.v);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            compare("B", e.tag, {so_b, fr_b, bz_b, dn_b, rdy_b}, e.v);
        end
        if (qc.size() > 0) begin
            e = qc.pop_front();
            compare("C", e.tag, {so_c, fr_c, bz_c, dn_c, rdy_c}, e.v);
        end
    end

    // One cycle of stimulus for instance sel (0=A, 1=B, 2=C), plus the
    // outputs expected from that instance during the same cycle.
    task automatic drive(input int sel, input logic rst, input logic v,
                         input logic [7:0] d, input logic [4:0] e, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        reset   = rst;
        data    = d;
        valid_a = (sel == 0) ? v : 1'b0;
        valid_b = (sel == 1) ? v : 1'b0;
        valid_c = (sel == 2) ? v : 1'b0;
        x.v   = e;
        x.tag = tag;
        case (sel)
            0:       qa.push_back(x);
            1:       qb.push_back(x);
            2:       qc.push_back(x);
            default: qa.push_back(x);
        endcase
    endtask

    initial begin
        exp_t x;
        logic [7:0] pa5;
        logic [7:0] p3c;
        logic [3:0] p9;
        pa5 = 8'hA5;
        p3c = 8'h3C;
        p9  = 4'h9;
        pass_cnt  = 0;
        total_cnt = 0;
        reset   = 1'b1;
        data    = 8'h00;
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;

        // Reset state on all instances, then release.
        @(posedge clk);
        #1;
        x.v = 5'b00000; x.tag = "reset_state";
        qa.push_back(x); qb.push_back(x); qc.push_back(x);
        @(posedge clk);
        #1;
        reset = 1'b0;
        x.v = 5'b00001; x.tag = "reset_release";
        qa.push_back(x); qb.push_back(x); qc.push_back(x);

        // 1: single A5 frame with one gap cycle.
        drive(0, 1'b0, 1'b1, 8'hA5, 5'b00001, "t1_handshake");
        for (int i = 0; i < 8; i++)
            drive(0, 1'b0, 1'b0, 8'h00, {pa5[7-i], 4'b1100}, "t1_bit");
        drive(0, 1'b0, 1'b0, 8'h00, 5'b00110, "t1_gap_done");
        drive(0, 1'b0, 1'b0, 8'h00, 5'b00001, "t1_idle");

        // 3: in_valid held with new data during SHIFT; 3C taken only when ready returns.
        drive(0, 1'b0, 1'b1, 8'hA5, 5'b00001, "t3_handshake");
        for (int i = 0; i < 8; i++)
            drive(0, 1'b0, 1'b1, 8'h3C, {pa5[7-i], 4'b1100}, "t3_a5_bit");
        drive(0, 1'b0, 1'b1, 8'h3C, 5'b00110, "t3_gap_done");
        drive(0, 1'b0, 1'b1, 8'h3C, 5'b00001, "t3_accept_3c");
        for (int i = 0; i < 8; i++)
            drive(0, 1'b0, 1'b0, 8'h00, {p3c[7-i], 4'b1100}, "t3_3c_bit");
        drive(0, 1'b0, 1'b0, 8'h00, 5'b00110, "t3_3c_done");
        drive(0, 1'b0, 1'b0, 8'h00, 5'b00001, "t3_idle");

        // 4: reset pulse on the 4th bit aborts the frame.
        drive(0, 1'b0, 1'b1, 8'hA5, 5'b00001, "t4_handshake");
        for (int i = 0; i < 3; i++)
            drive(0, 1'b0, 1'b0, 8'h00, {pa5[7-i], 4'b1100}, "t4_bit");
        drive(0, 1'b1, 1'b0, 8'h00, 5'b01100, "t4_bit4_in_reset");
        for (int i = 0; i < 6; i++)
            drive(0, 1'b0, 1'b0, 8'h00, 5'b00001, "t4_aborted_idle");

        // 6: handshake attempted while reset is high is not captured.
        drive(0, 1'b1, 1'b1, 8'hFF, 5'b00000, "t6_reset_handshake");
        for (int i = 0; i < 3; i++)
            drive(0, 1'b0, 1'b0, 8'h00, 5'b00001, "t6_no_frame");

        // 2: back-to-back FF then 00 with no gap.
        drive(1, 1'b0, 1'b1, 8'hFF, 5'b00001, "t2_handshake_ff");
        for (int i = 0; i < 7; i++)
            drive(1, 1'b0, 1'b0, 8'h00, 5'b11100, "t2_ff_bit");
        drive(1, 1'b0, 1'b1, 8'h00, 5'b11101, "t2_ff_last_reload");
        for (int i = 0; i < 8; i++)
            drive(1, 1'b0, 1'b0, 8'h00, {3'b011, (i == 0), (i == 7)}, "t2_00_bit");
        drive(1, 1'b0, 1'b0, 8'h00, 5'b00011, "t2_done2");
        drive(1, 1'b0, 1'b0, 8'h00, 5'b00001, "t2_idle");

        // 5: N=4, three gap cycles after 4'h9.
        drive(2, 1'b0, 1'b1, 8'h09, 5'b00001, "t5_handshake");
        for (int i = 0; i < 4; i++)
            drive(2, 1'b0, 1'b0, 8'h00, {p9[3-i], 4'b1100}, "t5_bit");
        drive(2, 1'b0, 1'b0, 8'h00, 5'b00110, "t5_gap1_done");
        drive(2, 1'b0, 1'b0, 8'h00, 5'b00100, "t5_gap2");
        drive(2, 1'b0, 1'b0, 8'h00, 5'b00100, "t5_gap3");
        drive(2, 1'b0, 1'b0, 8'h00, 5'b00001, "t5_idle");

        // Let the monitor consume the last expectation, then confirm nothing is left.
        @(negedge clk);
        #1;
        total_cnt++;
        if (qa.size() + qb.size() + qc.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     qa.size() + qb.size() + qc.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
